// File: rtl/repl_pkg.sv
// Shared definitions for the replacement-order tracker: policy encodings
// and a constant-foldable log2 used to size rank fields.
package repl_pkg;

  localparam int REPL_FIFO = 0;
  localparam int REPL_LRU  = 1;

  // Ceiling log2; returns the number of bits needed to index n entries.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/repl_rank_cell.sv
// One way's age rank. Loads its index on reset, then moves by at most one
// step per cycle under control of the top-level compare logic.
// Priority: load_max > load_min > dec > inc > hold.
module repl_rank_cell #(
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] init,
  input  logic          load_max,
  input  logic          load_min,
  input  logic          dec,
  input  logic          inc,
  output logic [RW-1:0] rank
);

  logic [RW-1:0] rank_d;
  logic [RW-1:0] rank_q;

  // Next-rank selection; WAYS is a power of two so the maximum rank is all ones.
  always_comb begin
    rank_d = rank_q;
    if (load_max) begin
      rank_d = {RW{1'b1}};
    end else if (load_min) begin
      rank_d = {RW{1'b0}};
    end else if (dec) begin
      rank_d = rank_q - RW'(1'b1);
    end else if (inc) begin
      rank_d = rank_q + RW'(1'b1);
    end else begin
      rank_d = rank_q;
    end
  end

  // Rank register with synchronous reset to the way's initial position.
  always_ff @(posedge clk) begin
    if (reset) begin
      rank_q <= init;
    end else begin
      rank_q <= rank_d;
    end
  end

  assign rank = rank_q;

endmodule

// File: rtl/repl_order_tracker.sv
// Per-set replacement-order tracker. Keeps a rank permutation and valid
// bits for WAYS ways, applies one of fill/invalidate/hit per cycle and
// presents the next victim way decoded from registered state only.
module repl_order_tracker
  import repl_pkg::*;
#(
  parameter  int WAYS = 8,
  parameter  int MODE = REPL_FIFO,
  localparam int RW   = clog2(WAYS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fill_vld,
  input  logic [RW-1:0]      fill_way,
  input  logic               hit_vld,
  input  logic [RW-1:0]      hit_way,
  input  logic               inv_vld,
  input  logic [RW-1:0]      inv_way,
  output logic [RW-1:0]      victim_way,
  output logic               all_valid,
  output logic [WAYS*RW-1:0] ranks,
  output logic [WAYS-1:0]    valid
);

  localparam logic MODE_LRU = (MODE == REPL_LRU);

  logic [WAYS-1:0] valid_d;
  logic [WAYS-1:0] valid_q;
  logic [RW-1:0]   rank_s [WAYS];

  logic            do_fill_s;
  logic            do_inv_s;
  logic            do_hit_s;
  logic            promote_s;
  logic [RW-1:0]   op_way_s;
  logic [RW-1:0]   ref_rank_s;

  logic [WAYS-1:0] load_max_s;
  logic [WAYS-1:0] load_min_s;
  logic [WAYS-1:0] dec_s;
  logic [WAYS-1:0] inc_s;

  logic [RW-1:0]   victim_s;
  logic            found_s;

  // Operation priority: fill beats invalidate beats hit; losers are dropped.
  always_comb begin
    do_fill_s = 1'b0;
    do_inv_s  = 1'b0;
    do_hit_s  = 1'b0;
    op_way_s  = hit_way;
    if (fill_vld) begin
      do_fill_s = 1'b1;
      op_way_s  = fill_way;
    end else if (inv_vld) begin
      do_inv_s  = 1'b1;
      op_way_s  = inv_way;
    end else if (hit_vld && MODE_LRU && valid_q[hit_way]) begin
      do_hit_s  = 1'b1;
      op_way_s  = hit_way;
    end else begin
      op_way_s  = hit_way;
    end
    promote_s  = do_fill_s | do_hit_s;
    ref_rank_s = rank_s[op_way_s];
  end

  // Per-way compare against the target's current rank drives the cell controls.
  always_comb begin
    load_max_s = '0;
    load_min_s = '0;
    dec_s      = '0;
    inc_s      = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (op_way_s == RW'(i)) begin
        load_max_s[i] = promote_s;
        load_min_s[i] = do_inv_s;
      end else begin
        dec_s[i] = promote_s && (rank_s[i] > ref_rank_s);
        inc_s[i] = do_inv_s  && (rank_s[i] < ref_rank_s);
      end
    end
  end

  // Valid-bit next state: fill sets, invalidate clears, hits never touch it.
  always_comb begin
    valid_d = valid_q;
    if (do_fill_s) begin
      valid_d[fill_way] = 1'b1;
    end else if (do_inv_s) begin
      valid_d[inv_way] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid register; reset overrides any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    repl_rank_cell #(
      .RW(RW)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .init     (RW'(g)),
      .load_max (load_max_s[g]),
      .load_min (load_min_s[g]),
      .dec      (dec_s[g]),
      .inc      (inc_s[g]),
      .rank     (rank_s[g])
    );
    assign ranks[g*RW +: RW] = rank_s[g];
  end

  // Victim: lowest-index invalid way, else the way holding rank 0.
  always_comb begin
    victim_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found_s && !valid_q[i]) begin
        victim_s = RW'(i);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      if (!found_s && (rank_s[i] == '0)) begin
        victim_s = RW'(i);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign victim_way = victim_s;
  assign all_valid  = &valid_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_repl_order_tracker.sv
// Bench for repl_order_tracker: one FIFO and one LRU instance share stimulus;
// a reference model pushes expected state per step and compares after the edge.
module tb_repl_order_tracker;

  localparam int WAYS = 8;
  localparam int RW   = 3;

  typedef struct packed {
    logic [WAYS*RW-1:0] ranks;
    logic [WAYS-1:0]    valid;
    logic [RW-1:0]      victim;
    logic               all_valid;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fill_vld = 1'b0, hit_vld = 1'b0, inv_vld = 1'b0;
  logic [RW-1:0] fill_way = '0, hit_way = '0, inv_way = '0;

  logic [RW-1:0]      victim_f, victim_l;
  logic               all_valid_f, all_valid_l;
  logic [WAYS*RW-1:0] ranks_f, ranks_l;
  logic [WAYS-1:0]    valid_f, valid_l;

  int passed = 0;
  int total  = 0;

  logic [RW-1:0] mr [2][WAYS];
  logic          mv [2][WAYS];
  exp_t          exp_q [$];

  always #5 clk = ~clk;

  repl_order_tracker #(.WAYS(WAYS), .MODE(0)) u_fifo (
    .clk(clk), .reset(reset),
    .fill_vld(fill_vld), .fill_way(fill_way),
    .hit_vld(hit_vld), .hit_way(hit_way),
    .inv_vld(inv_vld), .inv_way(inv_way),
    .victim_way(victim_f), .all_valid(all_valid_f),
    .ranks(ranks_f), .valid(valid_f)
  );

  repl_order_tracker #(.WAYS(WAYS), .MODE(1)) u_lru (
    .clk(clk), .reset(reset),
    .fill_vld(fill_vld), .fill_way(fill_way),
    .hit_vld(hit_vld), .hit_way(hit_way),
    .inv_vld(inv_vld), .inv_way(inv_way),
    .victim_way(victim_l), .all_valid(all_valid_l),
    .ranks(ranks_l), .valid(valid_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one tracker instance (m = 0 FIFO, 1 LRU).
  task automatic model_apply(input int m, input bit rst, input bit fv, input int fw,
                             input bit hv, input int hw, input bit iv, input int iw);
    logic [RW-1:0] r;
    int w;
    bit prom;
    prom = 1'b0;
    w = 0;
    if (rst) begin
      for (int j = 0; j < WAYS; j++) begin
        mr[m][j] = RW'(j);
        mv[m][j] = 1'b0;
      end
    end else if (fv) begin
      prom = 1'b1; w = fw; mv[m][fw] = 1'b1;
    end else if (iv) begin
      r = mr[m][iw];
      for (int j = 0; j < WAYS; j++) if (mr[m][j] < r) mr[m][j] = mr[m][j] + 3'd1;
      mr[m][iw] = 3'd0;
      mv[m][iw] = 1'b0;
    end else if (hv && m == 1 && mv[m][hw]) begin
      prom = 1'b1; w = hw;
    end
    if (prom) begin
      r = mr[m][w];
      for (int j = 0; j < WAYS; j++) if (mr[m][j] > r) mr[m][j] = mr[m][j] - 3'd1;
      mr[m][w] = 3'd7;
    end
  endtask

  function automatic exp_t model_state(input int m);
    exp_t e;
    bit found;
    found = 1'b0;
    e.victim = '0;
    for (int j = 0; j < WAYS; j++) begin
      e.ranks[j*RW +: RW] = mr[m][j];
      e.valid[j] = mv[m][j];
    end
    for (int j = 0; j < WAYS; j++)
      if (!found && !mv[m][j]) begin e.victim = RW'(j); found = 1'b1; end
    for (int j = 0; j < WAYS; j++)
      if (!found && mr[m][j] == 3'd0) begin e.victim = RW'(j); found = 1'b1; end
    e.all_valid = &e.valid;
    return e;
  endfunction

  task automatic step(input bit rst, input bit fv, input int fw, input bit hv,
                      input int hw, input bit iv, input int iw);
    exp_t e;
    reset = rst; fill_vld = fv; fill_way = RW'(fw);
    hit_vld = hv; hit_way = RW'(hw); inv_vld = iv; inv_way = RW'(iw);
    for (int m = 0; m < 2; m++) begin
      model_apply(m, rst, fv, fw, hv, hw, iv, iw);
      exp_q.push_back(model_state(m));
    end
    @(posedge clk);
    #1;
    reset = 1'b0; fill_vld = 1'b0; hit_vld = 1'b0; inv_vld = 1'b0;
    e = exp_q.pop_front();
    chk("fifo_ranks",  32'(ranks_f),     32'(e.ranks));
    chk("fifo_valid",  32'(valid_f),     32'(e.valid));
    chk("fifo_victim", 32'(victim_f),    32'(e.victim));
    chk("fifo_allv",   32'(all_valid_f), 32'(e.all_valid));
    e = exp_q.pop_front();
    chk("lru_ranks",   32'(ranks_l),     32'(e.ranks));
    chk("lru_valid",   32'(valid_l),     32'(e.valid));
    chk("lru_victim",  32'(victim_l),    32'(e.victim));
    chk("lru_allv",    32'(all_valid_l), 32'(e.all_valid));
  endtask

  function automatic logic [RW-1:0] rk(input logic [WAYS*RW-1:0] p, input int w);
    return p[w*RW +: RW];
  endfunction

  logic [WAYS*RW-1:0] reset_pack;
  logic [WAYS-1:0]    seen;

  initial begin
    for (int j = 0; j < WAYS; j++) reset_pack[j*RW +: RW] = RW'(j);
    @(posedge clk);
    #1;

    // 1: reset then idle
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t1_ranks",  32'(ranks_f),     32'(reset_pack));
    chk("t1_valid",  32'(valid_f),     32'h0);
    chk("t1_victim", 32'(victim_f),    32'h0);
    chk("t1_allv",   32'(all_valid_f), 32'h0);

    // 2/3: fill 0..7, hit way 0, refill way 0
    for (int w = 0; w < WAYS; w++) step(0, 1, w, 0, 0, 0, 0);
    chk("t2_allv",   32'(all_valid_f), 32'h1);
    chk("t2_victim", 32'(victim_f),    32'h0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t3_fifo_ranks",  32'(ranks_f),      32'(reset_pack));
    chk("t3_fifo_victim", 32'(victim_f),     32'h0);
    chk("t3_lru_victim",  32'(victim_l),     32'h1);
    chk("t3_lru_rank0",   32'(rk(ranks_l, 0)), 32'h7);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t2_refill_victim", 32'(victim_f),        32'h1);
    chk("t2_refill_rank0",  32'(rk(ranks_f, 0)),  32'h7);
    chk("t2_refill_rank1",  32'(rk(ranks_f, 1)),  32'h0);

    // 4: invalidate way 5 at rank 5
    step(1, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < WAYS; w++) step(0, 1, w, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5);
    chk("t4_victim", 32'(victim_f),       32'h5);
    chk("t4_rank5",  32'(rk(ranks_f, 5)), 32'h0);
    chk("t4_rank0",  32'(rk(ranks_f, 0)), 32'h1);
    chk("t4_rank4",  32'(rk(ranks_f, 4)), 32'h5);
    chk("t4_allv",   32'(all_valid_f),    32'h0);

    // 5: fill/invalidate/hit collide; only the fill applies
    step(0, 1, 2, 1, 6, 1, 2);
    chk("t5_valid2", 32'(valid_l[2]),     32'h1);
    chk("t5_rank2",  32'(rk(ranks_l, 2)), 32'h7);
    chk("t5_rank6",  32'(rk(ranks_l, 6)), 32'h5);

    // 6: reset overrides a fill mid-sequence
    step(1, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < 4; w++) step(0, 1, w, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0);
    chk("t6_ranks",  32'(ranks_f),  32'(reset_pack));
    chk("t6_valid",  32'(valid_f),  32'h0);
    chk("t6_victim", 32'(victim_f), 32'h0);

    // random mix of operations
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0), $urandom_range(0, WAYS-1),
           ($urandom_range(0, 1) == 0), $urandom_range(0, WAYS-1),
           ($urandom_range(0, 3) == 0), $urandom_range(0, WAYS-1));
      seen = '0;
      for (int j = 0; j < WAYS; j++) seen[rk(ranks_l, j)] = 1'b1;
      chk("perm_lru", 32'(seen), 32'hFF);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
